// File: rtl/sr_cmd_driver.sv
// Command stage for a clocked SR flip-flop: turns SET/CLEAR/TOGGLE/HOLD commands into
// timed s/r pulses and checks the flop's q afterwards, flagging any mismatch (sticky).
module sr_cmd_driver #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  output logic       cmd_ready,
  input  logic       q,
  input  logic       err_clr,
  output logic       s,
  output logic       r,
  output logic       busy,
  output logic       done,
  output logic       mismatch
);

  // A zero pulse length degrades to a single-cycle pulse.
  localparam int unsigned PULSE_LOAD = (PULSE_CYCLES == 0) ? 0 : PULSE_CYCLES - 1;
  localparam int unsigned GAP_LOAD   = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             expv, expv_d;
  logic             s_d, r_d, busy_d, done_d, mismatch_d;

  assign cmd_ready = (state == IDLE);

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      expv     <= 1'b0;
      s        <= 1'b0;
      r        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      expv     <= expv_d;
      s        <= s_d;
      r        <= r_d;
      busy     <= busy_d;
      done     <= done_d;
      mismatch <= mismatch_d;
    end
  end

  // Next state and next registered outputs; s/r are derived from one expected bit so
  // they can never both be high.
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    expv_d     = expv;
    s_d        = 1'b0;
    r_d        = 1'b0;
    done_d     = 1'b0;
    mismatch_d = err_clr ? 1'b0 : mismatch;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_HOLD) begin
            done_d = 1'b1;
          end else begin
            if (cmd_op == OP_SET)        expv_d = 1'b1;
            else if (cmd_op == OP_CLEAR) expv_d = 1'b0;
            else                         expv_d = ~q;
            state_d = PULSE;
            cnt_d   = CNT_W'(PULSE_LOAD);
            s_d     = expv_d;
            r_d     = ~expv_d;
          end
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          if (GAP_CYCLES > 0) begin
            state_d = GAP;
            cnt_d   = CNT_W'(GAP_LOAD);
          end else begin
            state_d = CHECK;
          end
        end else begin
          cnt_d = cnt - CNT_W'(1);
          s_d   = expv;
          r_d   = ~expv;
        end
      end
      GAP: begin
        if (cnt == '0) state_d = CHECK;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      CHECK: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (q != expv) mismatch_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Randomized + directed bench for sr_cmd_driver; a timeline model (cycles since accept)
// predicts every output, and a second instance covers the 1-cycle pulse / no-gap build.
module tb_sr_cmd_driver;

  localparam int P  = 2;
  localparam int G  = 1;
  localparam int CK = P + G + 1;   // cycles after accept at which the check edge falls

  logic clk = 1'b0;
  logic rst_n;
  logic cmd_valid, err_clr, broken;
  logic [1:0] cmd_op;
  logic cmd_ready, s, r, busy, done, mismatch;
  logic q_ff;
  logic q;

  logic v2;
  logic [1:0] op2;
  logic ready2, s2, r2, busy2, done2, mis2;
  logic q2;

  int n_vec = 0;
  int n_err = 0;
  bit started = 0;

  always #5 clk = ~clk;

  assign q = broken ? 1'b0 : q_ff;

  sr_cmd_driver dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .q(q), .err_clr(err_clr), .s(s), .r(r),
    .busy(busy), .done(done), .mismatch(mismatch)
  );

  sr_cmd_driver #(.PULSE_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(v2), .cmd_op(op2),
    .cmd_ready(ready2), .q(q2), .err_clr(1'b0), .s(s2), .r(r2),
    .busy(busy2), .done(done2), .mismatch(mis2)
  );

  // Downstream SR flip-flops.
  always @(posedge clk) begin
    if (s) q_ff <= 1'b1;
    else if (r) q_ff <= 1'b0;
    if (s2) q2 <= 1'b1;
    else if (r2) q2 <= 1'b0;
  end

  task automatic chk(input string nm, input logic act, input logic ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, ex, $time);
    end
  endtask

  // Reference model: ph counts cycles since the accepting edge (0 = idle).
  int   ph;
  logic m_exp, m_mis, m_nd;
  logic e_s, e_r, e_busy, e_done, e_mis, e_ready;

  task automatic model_reset();
    ph = 0; m_exp = 1'b0; m_mis = 1'b0;
    e_s = 1'b0; e_r = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_mis = 1'b0; e_ready = 1'b1;
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      m_nd = 1'b0;
      if (ph == CK && q !== m_exp) m_mis = 1'b1;
      else if (err_clr)            m_mis = 1'b0;
      if (ph == 0) begin
        if (cmd_valid) begin
          if (cmd_op == 2'b00) m_nd = 1'b1;
          else begin
            m_exp = (cmd_op == 2'b01) ? 1'b1 : (cmd_op == 2'b10) ? 1'b0 : ~q;
            ph = 1;
          end
        end
      end else if (ph == CK) begin
        ph = 0;
        m_nd = 1'b1;
      end else begin
        ph++;
      end
      e_done  = m_nd;
      e_busy  = (ph != 0);
      e_ready = (ph == 0);
      e_s     = (ph >= 1 && ph <= P) && m_exp;
      e_r     = (ph >= 1 && ph <= P) && !m_exp;
      e_mis   = m_mis;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("s", s, e_s);
      chk("r", r, e_r);
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("mismatch", mismatch, e_mis);
      chk("cmd_ready", cmd_ready, e_ready);
      chk("s_and_r", s & r, 1'b0);
      chk("s2_and_r2", s2 & r2, 1'b0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue one command for a single cycle, leaving the bench one cycle after accept.
  task automatic issue(input logic [1:0] op);
    cmd_valid = 1'b1; cmd_op = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses, dones;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; err_clr = 1'b0; broken = 1'b0;
    v2 = 1'b0; op2 = 2'b00; q_ff = 1'b0; q2 = 1'b0;
    model_reset();
    #3 rst_n = 1'b0;
    started = 1;
    tick(); tick();
    chk("rst_s", s, 1'b0); chk("rst_busy", busy, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1); chk("rst_mis", mismatch, 1'b0);
    rst_n = 1'b1;
    tick();

    // 1: SET
    issue(2'b01);
    chk("t1_s_c1", s, 1'b1); chk("t1_r_c1", r, 1'b0);
    tick(); chk("t1_s_c2", s, 1'b1);
    tick(); chk("t1_s_c3", s, 1'b0);
    tick(); chk("t1_done_c4", done, 1'b0);
    tick(); chk("t1_done_c5", done, 1'b1); chk("t1_q", q, 1'b1);
    chk("t1_mis", mismatch, 1'b0); chk("t1_ready", cmd_ready, 1'b1);

    // 2: CLEAR then TOGGLE (q=0)
    issue(2'b10);
    chk("t2_r_c1", r, 1'b1);
    tick(); chk("t2_r_c2", r, 1'b1);
    repeat (3) tick();
    chk("t2_done", done, 1'b1); chk("t2_q0", q, 1'b0);
    issue(2'b11);
    chk("t2_tog_s", s, 1'b1); chk("t2_tog_r", r, 1'b0);
    repeat (4) tick();
    chk("t2_tog_done", done, 1'b1); chk("t2_q1", q, 1'b1); chk("t2_mis", mismatch, 1'b0);

    // 3: broken flop
    broken = 1'b1;
    issue(2'b01);
    repeat (4) tick();
    chk("t3_mis_set", mismatch, 1'b1);
    repeat (3) tick();
    chk("t3_mis_sticky", mismatch, 1'b1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_mis_clr", mismatch, 1'b0);
    broken = 1'b0;
    tick();

    // 4: valid held high during busy, then four HOLDs
    cmd_valid = 1'b1; cmd_op = 2'b01;
    pulses = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (s) pulses++;
      if (i == 5) chk("t4_ready_c5", cmd_ready, 1'b1);
      else chk("t4_ready_busy", cmd_ready, 1'b0);
    end
    n_vec++;
    if (pulses != 2) begin
      n_err++;
      $display("FAIL t4_pulse_cycles: got %0d, expected 2", pulses);
    end
    tick(); chk("t4_reaccept", s, 1'b1);
    cmd_valid = 1'b0;
    repeat (4) tick();
    chk("t4_done2", done, 1'b1);
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_op = 2'b00;
      tick();
      chk("t4_hold_done", done, 1'b1);
      if (done) dones++;
    end
    cmd_valid = 1'b0;
    tick(); chk("t4_hold_end", done, 1'b0);
    n_vec++;
    if (dones != 4) begin
      n_err++;
      $display("FAIL t4_hold_count: got %0d, expected 4", dones);
    end

    // 5: reset mid-pulse with mismatch set
    broken = 1'b1;
    issue(2'b01);
    repeat (4) tick();
    chk("t5_mis_pre", mismatch, 1'b1);
    issue(2'b01);
    chk("t5_s_pre", s, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("t5_s_async", s, 1'b0); chk("t5_busy_async", busy, 1'b0);
    chk("t5_mis_async", mismatch, 1'b0);
    broken = 1'b0;
    tick(); rst_n = 1'b1; tick();
    issue(2'b10);
    chk("t5_r", r, 1'b1);
    repeat (4) tick();
    chk("t5_done", done, 1'b1); chk("t5_q", q, 1'b0); chk("t5_mis", mismatch, 1'b0);

    // 6: PULSE_CYCLES=1, GAP_CYCLES=0 instance
    v2 = 1'b1; op2 = 2'b01;
    tick(); v2 = 1'b0;
    chk("t6_s_c1", s2, 1'b1); chk("t6_busy_c1", busy2, 1'b1);
    tick(); chk("t6_s_c2", s2, 1'b0); chk("t6_done_c2", done2, 1'b0);
    tick(); chk("t6_done_c3", done2, 1'b1); chk("t6_q", q2, 1'b1);
    chk("t6_ready", ready2, 1'b1); chk("t6_mis", mis2, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      err_clr   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) broken = ~broken;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end
    cmd_valid = 1'b0; err_clr = 1'b0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
